// File: rtl/nios2_system_switch_pio.sv
// nios2_system_switch_pio: Avalon-MM input PIO with sync, edge capture and IRQ.
// Define SWITCH_PIO_DEBOUNCE_EN to add per-bit debounce counters.
module nios2_system_switch_pio #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      EDGE_TYPE      = 0,
  parameter int unsigned      DB_CYCLES      = 16,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [1:0]       arm_cnt;
  logic             armed;

  logic             wr;
  logic             wr_mask;
  logic             wr_clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] edgecap_nxt;
  logic [WIDTH-1:0] irqmask_nxt;
  logic [31:0]      rd_nxt;

  assign armed   = (arm_cnt == 2'd3);
  assign wr      = chipselect & ~write_n;
  assign wr_mask = wr & (address == 2'd2);
  assign wr_clr  = wr & (address == 2'd3);
  assign wdata   = writedata[WIDTH-1:0];
  assign clr     = wr_clr ? wdata : '0;

  always_comb begin
    edge_bits = '0;
    if (armed) begin
      if (EDGE_TYPE == 0)
        edge_bits = db & ~prev;
      else if (EDGE_TYPE == 1)
        edge_bits = ~db & prev;
      else
        edge_bits = db ^ prev;
    end
  end

  // a new edge wins over a same-cycle clear of that bit
  assign edgecap_nxt = (edgecap & ~clr) | edge_bits;
  assign irqmask_nxt = wr_mask ? wdata : irqmask;

  always_comb begin
    rd_nxt = '0;
    unique case (address)
      2'd0: rd_nxt = 32'(db);
      2'd1: rd_nxt = '0;
      2'd2: rd_nxt = 32'(irqmask);
      2'd3: rd_nxt = 32'(edgecap);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      arm_cnt  <= '0;
      edgecap  <= '0;
      irqmask  <= IRQ_MASK_RESET;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      if (!armed)
        arm_cnt <= arm_cnt + 2'd1;
      prev     <= armed ? db : sync2;
      edgecap  <= edgecap_nxt;
      irqmask  <= irqmask_nxt;
      irq      <= |(edgecap_nxt & irqmask_nxt);
      readdata <= rd_nxt;
    end
  end

`ifdef SWITCH_PIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] db_cnt [WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < WIDTH; i++)
        db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!armed) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      db <= '0;
    else
      db <= sync2;
  end
`endif

endmodule
